// File: rtl/router_pkg.sv
// Shared definitions for the router register block: parity modes and the parity fold helper.
package router_pkg;

  typedef enum logic {
    PAR_XOR = 1'b0,
    PAR_SUM = 1'b1
  } parity_mode_e;

  // Widest supported data byte; callers zero-extend into and truncate out of this width.
  localparam int unsigned MaxDw = 64;

  function automatic logic [MaxDw-1:0] parity_fold(parity_mode_e mode,
                                                    logic [MaxDw-1:0] acc,
                                                    logic [MaxDw-1:0] data);
    if (mode == PAR_SUM) begin
      return acc + data;
    end
    return acc ^ data;
  endfunction

endpackage

// File: rtl/router_reg_param_if.sv
// Controller/stream/FIFO-side signal bundle of the router register block.
interface router_reg_param_if #(
  parameter int unsigned DW         = 8,
  parameter int unsigned HOLD_DEPTH = 2
);
  localparam int unsigned CntW = $clog2(HOLD_DEPTH + 1);

  logic            pkt_vld;
  logic            fifo_full;
  logic            detect_add;
  logic            lfd_state;
  logic            ld_state;
  logic            laf_state;
  logic            full_state;
  logic            rst_int_reg;
  logic [DW-1:0]   data_in;
  logic [DW-1:0]   dout;
  logic            dout_vld;
  logic            low_pkt_vld;
  logic            parity_done;
  logic            err;
  logic            hold_ovf;
  logic [CntW-1:0] hold_cnt;

  modport master (
    output pkt_vld, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, data_in,
    input  dout, dout_vld, low_pkt_vld, parity_done, err, hold_ovf, hold_cnt
  );

  modport slave (
    input  pkt_vld, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, data_in,
    output dout, dout_vld, low_pkt_vld, parity_done, err, hold_ovf, hold_cnt
  );

endinterface

// File: rtl/router_hold_buf.sv
// Small in-order hold buffer; entry 0 is always the oldest. Pushes into a full buffer are ignored.
module router_hold_buf
  import router_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned HOLD_DEPTH = 2,
  localparam int unsigned CntW      = $clog2(HOLD_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  logic [DW-1:0]   mem_q [HOLD_DEPTH];
  logic [DW-1:0]   mem_d [HOLD_DEPTH];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CntW'(HOLD_DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[0];
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      for (int unsigned i = 0; i + 1 < HOLD_DEPTH; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d = cnt_d - CntW'(1);
    end
    if (do_push) begin
      // Write slot is the post-pop occupancy.
      for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
        if (CntW'(i) == cnt_d) begin
          mem_d[i] = din;
        end
      end
      cnt_d = cnt_d + CntW'(1);
    end
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/router_reg_param.sv
// Router register block: header latch, payload routing with overflow hold buffer, parity check.
module router_reg_param
  import router_pkg::*;
#(
  parameter int unsigned  DW          = 8,
  parameter int unsigned  HOLD_DEPTH  = 2,
  parameter parity_mode_e PARITY_MODE = PAR_XOR
) (
  input logic               clk,
  input logic               rst,
  router_reg_param_if.slave bus
);

  localparam int unsigned CntW = $clog2(HOLD_DEPTH + 1);

  logic [DW-1:0]   header_q, header_d;
  logic [DW-1:0]   int_par_q, int_par_d;
  logic [DW-1:0]   pkt_par_q, pkt_par_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic            low_q, low_d;
  logic            done_q, done_d, done_dly_q;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            hb_push, hb_pop, hb_flush, hb_full, hb_empty;
  logic [DW-1:0]   hb_dout;
  logic [CntW-1:0] hb_cnt;
  logic            unused_full_state;

  assign unused_full_state = bus.full_state;

  router_hold_buf #(
    .DW         (DW),
    .HOLD_DEPTH (HOLD_DEPTH)
  ) u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (hb_push),
    .pop   (hb_pop),
    .flush (hb_flush),
    .din   (bus.data_in),
    .dout  (hb_dout),
    .count (hb_cnt),
    .full  (hb_full),
    .empty (hb_empty)
  );

  always_comb begin
    header_d   = header_q;
    int_par_d  = int_par_q;
    pkt_par_d  = pkt_par_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    low_d      = low_q;
    done_d     = done_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    hb_push    = 1'b0;
    hb_pop     = 1'b0;
    hb_flush   = bus.rst_int_reg & ~bus.pkt_vld;

    // Clears first so that a same-cycle set from the strobe decode wins.
    if (bus.rst_int_reg) begin
      low_d = 1'b0;
      if (!bus.pkt_vld) begin
        pkt_par_d = '0;
      end
    end
    if (low_q && hb_empty) begin
      done_d = 1'b1;
    end
    if (done_q && !done_dly_q) begin
      err_d = (int_par_q != pkt_par_q);
    end

    if (bus.detect_add) begin
      if (bus.pkt_vld) begin
        header_d  = bus.data_in;
        int_par_d = '0;
        pkt_par_d = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovf_d     = 1'b0;
      end
    end else if (bus.lfd_state) begin
      dout_d     = header_q;
      dout_vld_d = 1'b1;
      int_par_d  = header_q;
    end else if (bus.ld_state) begin
      if (!bus.fifo_full && hb_empty) begin
        dout_d     = bus.data_in;
        dout_vld_d = 1'b1;
      end else begin
        hb_push = 1'b1;
        if (hb_full) begin
          ovf_d = 1'b1;
        end
      end
      if (bus.pkt_vld) begin
        // Dropped bytes still fold so the check flags the corrupted packet.
        int_par_d = DW'(parity_fold(PARITY_MODE, MaxDw'(int_par_q), MaxDw'(bus.data_in)));
      end else begin
        pkt_par_d = bus.data_in;
        low_d     = 1'b1;
      end
    end else if (bus.laf_state) begin
      if (!bus.fifo_full && !hb_empty) begin
        dout_d     = hb_dout;
        dout_vld_d = 1'b1;
        hb_pop     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      header_q   <= '0;
      int_par_q  <= '0;
      pkt_par_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      low_q      <= 1'b0;
      done_q     <= 1'b0;
      done_dly_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      header_q   <= header_d;
      int_par_q  <= int_par_d;
      pkt_par_q  <= pkt_par_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      low_q      <= low_d;
      done_q     <= done_d;
      done_dly_q <= done_q;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_vld    = dout_vld_q;
  assign bus.low_pkt_vld = low_q;
  assign bus.parity_done = done_q;
  assign bus.err         = err_q;
  assign bus.hold_ovf    = ovf_q;
  assign bus.hold_cnt    = hb_cnt;

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench: an XOR-parity and a SUM-parity instance driven with identical stimulus.
module tb_router_reg_param;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  router_reg_param_if #(.DW(8), .HOLD_DEPTH(2)) bus_x ();
  router_reg_param_if #(.DW(8), .HOLD_DEPTH(2)) bus_s ();

  router_reg_param #(.DW(8), .HOLD_DEPTH(2), .PARITY_MODE(PAR_XOR)) dut_x (
    .clk (clk),
    .rst (rst),
    .bus (bus_x)
  );

  router_reg_param #(.DW(8), .HOLD_DEPTH(2), .PARITY_MODE(PAR_SUM)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic set_in(input logic da, input logic lfd, input logic ld, input logic laf,
                        input logic pv, input logic ff, input logic ri, input logic [7:0] d);
    bus_x.detect_add = da;  bus_s.detect_add = da;
    bus_x.lfd_state  = lfd; bus_s.lfd_state  = lfd;
    bus_x.ld_state   = ld;  bus_s.ld_state   = ld;
    bus_x.laf_state  = laf; bus_s.laf_state  = laf;
    bus_x.pkt_vld    = pv;  bus_s.pkt_vld    = pv;
    bus_x.fifo_full  = ff;  bus_s.fifo_full  = ff;
    bus_x.rst_int_reg = ri; bus_s.rst_int_reg = ri;
    bus_x.full_state = 1'b0; bus_s.full_state = 1'b0;
    bus_x.data_in    = d;   bus_s.data_in    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk8("rst_dout", bus_x.dout, 8'h00);
    chk1("rst_vld", bus_x.dout_vld, 1'b0);
    chk1("rst_low", bus_x.low_pkt_vld, 1'b0);
    chk1("rst_done", bus_x.parity_done, 1'b0);
    chk1("rst_err", bus_x.err, 1'b0);
    chk1("rst_ovf", bus_x.hold_ovf, 1'b0);
    chk8("rst_cnt", 8'(bus_x.hold_cnt), 8'h00);
    rst = 1'b0;

    // Packet A: 05 ^ 11 ^ 22 ^ 33 ^ 44 = 41, matching parity.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05); tick();
    chk1("a_hdr_vld", bus_x.dout_vld, 1'b0);
    chk8("a_hdr_dout", bus_x.dout, 8'h00);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk8("a_lfd_dout", bus_x.dout, 8'h05);
    chk1("a_lfd_vld", bus_x.dout_vld, 1'b1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11); tick();
    chk8("a_p0", bus_x.dout, 8'h11);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22); tick();
    chk8("a_p1", bus_x.dout, 8'h22);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33); tick();
    chk8("a_p2", bus_x.dout, 8'h33);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44); tick();
    chk8("a_p3", bus_x.dout, 8'h44);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41); tick();
    chk8("a_par_dout", bus_x.dout, 8'h41);
    chk1("a_par_vld", bus_x.dout_vld, 1'b1);
    chk1("a_low", bus_x.low_pkt_vld, 1'b1);
    chk1("a_done_early", bus_x.parity_done, 1'b0);
    idle(); tick();
    chk1("a_done", bus_x.parity_done, 1'b1);
    chk1("a_idle_vld", bus_x.dout_vld, 1'b0);
    tick();
    chk1("a_err", bus_x.err, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); tick();
    chk1("a_low_clr", bus_x.low_pkt_vld, 1'b0);
    chk1("a_done_hold", bus_x.parity_done, 1'b1);

    // Packet B: same bytes, wrong parity 60.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05); tick();
    chk1("b_done_clr", bus_x.parity_done, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h60); tick();
    chk8("b_par_dout", bus_x.dout, 8'h60);
    idle(); tick();
    chk1("b_done", bus_x.parity_done, 1'b1);
    chk1("b_err_lag", bus_x.err, 1'b0);
    tick();
    chk1("b_err", bus_x.err, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); tick();
    chk1("b_err_sticky", bus_x.err, 1'b1);

    // Packet C: stall on 22/33, drain, then parity held behind a full FIFO.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05); tick();
    chk1("c_err_clr", bus_x.err, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk8("c_lfd", bus_x.dout, 8'h05);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11); tick();
    chk8("c_p0", bus_x.dout, 8'h11);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22); tick();
    chk1("c_push1_vld", bus_x.dout_vld, 1'b0);
    chk8("c_cnt1", 8'(bus_x.hold_cnt), 8'h01);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33); tick();
    chk8("c_cnt2", 8'(bus_x.hold_cnt), 8'h02);
    chk1("c_no_ovf", bus_x.hold_ovf, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk8("c_pop1", bus_x.dout, 8'h22);
    chk1("c_pop1_vld", bus_x.dout_vld, 1'b1);
    tick();
    chk8("c_pop2", bus_x.dout, 8'h33);
    chk8("c_cnt0", 8'(bus_x.hold_cnt), 8'h00);
    tick();
    chk1("c_laf_empty_vld", bus_x.dout_vld, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44); tick();
    chk8("c_p3", bus_x.dout, 8'h44);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41); tick();
    chk8("c_par_held", 8'(bus_x.hold_cnt), 8'h01);
    chk1("c_low", bus_x.low_pkt_vld, 1'b1);
    idle(); tick();
    chk1("c_done_gated", bus_x.parity_done, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk8("c_par_pop", bus_x.dout, 8'h41);
    chk1("c_done_gated2", bus_x.parity_done, 1'b0);
    idle(); tick();
    chk1("c_done", bus_x.parity_done, 1'b1);
    tick();
    chk1("c_err", bus_x.err, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); tick();

    // Packet D: three stalled bytes overflow a two-entry buffer.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05); tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22); tick();
    chk1("d_ovf_early", bus_x.hold_ovf, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33); tick();
    chk1("d_ovf", bus_x.hold_ovf, 1'b1);
    chk8("d_cnt_sat", 8'(bus_x.hold_cnt), 8'h02);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk8("d_pop_oldest", bus_x.dout, 8'h11);
    chk1("d_ovf_sticky", bus_x.hold_ovf, 1'b1);
    chk8("d_cnt1", 8'(bus_x.hold_cnt), 8'h01);

    // Reset mid-payload with one entry held, competing with an ld strobe.
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA); tick();
    chk8("r_dout", bus_x.dout, 8'h00);
    chk1("r_vld", bus_x.dout_vld, 1'b0);
    chk1("r_ovf", bus_x.hold_ovf, 1'b0);
    chk8("r_cnt", 8'(bus_x.hold_cnt), 8'h00);
    chk1("r_done", bus_x.parity_done, 1'b0);
    chk1("r_err", bus_x.err, 1'b0);
    rst = 1'b0;

    // Packet E: F0 + 20 wraps to 10 under SUM; XOR gives D0, so only SUM matches.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0); tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk8("e_lfd_s", bus_s.dout, 8'hF0);
    chk8("e_lfd_x", bus_x.dout, 8'hF0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20); tick();
    chk8("e_p0_s", bus_s.dout, 8'h20);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10); tick();
    chk8("e_par_s", bus_s.dout, 8'h10);
    idle(); tick();
    chk1("e_done_s", bus_s.parity_done, 1'b1);
    chk1("e_done_x", bus_x.parity_done, 1'b1);
    tick();
    chk1("e_err_sum", bus_s.err, 1'b0);
    chk1("e_err_xor", bus_x.err, 1'b1);
    chk1("e_ovf_x", bus_x.hold_ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
